// File: rtl/ppu_reg_file_pkg.sv
// Shared types for the CPU-facing PPU register responder.
package ppu_reg_file_pkg;

    typedef enum logic [3:0] {
        REG_PPUCTRL   = 4'd0,
        REG_PPUMASK   = 4'd1,
        REG_PPUSTATUS = 4'd2,
        REG_OAMADDR   = 4'd3,
        REG_OAMDATA   = 4'd4,
        REG_PPUSCROLL = 4'd5,
        REG_PPUADDR   = 4'd6,
        REG_PPUDATA   = 4'd7,
        REG_OAMDMA    = 4'd8
    } reg_t;

    typedef logic [1:0] vram_state_t;

    localparam vram_state_t VS_IDLE   = 2'd0;
    localparam vram_state_t VS_RD_CAP = 2'd1;
    localparam vram_state_t VS_WR_STB = 2'd2;

    localparam logic [5:0] PALETTE_HI = 6'h3F;

endpackage

// File: rtl/ppu_reg_file_vram.sv
// PPUDATA side of the register file: VRAM strobe FSM, read buffer and v.
//   state     | meaning
//   VS_IDLE   | waiting for a PPUDATA access
//   VS_RD_CAP | read strobe out; capture vram_rd_data into rd_buf
//   VS_WR_STB | write strobe out; drop it next clock
module ppu_vram_access
    import ppu_reg_file_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [7:0]  wr_data,
    input  logic        inc32,
    input  logic        v_load,
    input  logic [14:0] v_load_val,
    input  logic [7:0]  vram_rd_data,
    output logic [14:0] v_addr,
    output logic [13:0] vram_addr,
    output logic        vram_rd_en,
    output logic        vram_wr_en,
    output logic [7:0]  vram_wr_data,
    output logic        data_load,
    output logic [7:0]  data_value
);

    vram_state_t state;
    logic [7:0]  rd_buf;
    logic        pal_q;
    logic        is_pal;
    logic [14:0] v_step;

    assign is_pal = (v_addr[13:8] == PALETTE_HI);
    assign v_step = inc32 ? 15'd32 : 15'd1;

    // Non-palette reads answer from the stale buffer at once; palette reads answer in RD_CAP.
    always_comb begin
        data_load  = 1'b0;
        data_value = rd_buf;
        if (state == VS_IDLE && rd_req && !is_pal) begin
            data_load = 1'b1;
        end else if (state == VS_RD_CAP && pal_q) begin
            data_load  = 1'b1;
            data_value = vram_rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= VS_IDLE;
            rd_buf       <= 8'h00;
            pal_q        <= 1'b0;
            v_addr       <= 15'h0000;
            vram_addr    <= 14'h0000;
            vram_rd_en   <= 1'b0;
            vram_wr_en   <= 1'b0;
            vram_wr_data <= 8'h00;
        end else begin
            if (v_load) v_addr <= v_load_val;
            case (state)
                VS_IDLE: begin
                    if (rd_req) begin
                        vram_addr  <= v_addr[13:0];
                        vram_rd_en <= 1'b1;
                        pal_q      <= is_pal;
                        v_addr     <= v_addr + v_step;
                        state      <= VS_RD_CAP;
                    end else if (wr_req) begin
                        vram_addr    <= v_addr[13:0];
                        vram_wr_data <= wr_data;
                        vram_wr_en   <= 1'b1;
                        v_addr       <= v_addr + v_step;
                        state        <= VS_WR_STB;
                    end
                end
                VS_RD_CAP: begin
                    rd_buf     <= vram_rd_data;
                    vram_rd_en <= 1'b0;
                    state      <= VS_IDLE;
                end
                VS_WR_STB: begin
                    vram_wr_en <= 1'b0;
                    state      <= VS_IDLE;
                end
                default: state <= VS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ppu_reg_file.sv
// CPU-facing PPU register responder: decodes register accesses and applies side effects.
module ppu_reg_file
    import ppu_reg_file_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clock_en,
    input  logic        reg_en,
    input  logic        reg_rw,
    input  reg_t        reg_sel,
    input  logic [7:0]  reg_data_wr,
    output logic [7:0]  reg_data_rd,
    input  logic        vblank_set,
    input  logic        vblank_clear,
    input  logic        sprite0_hit_set,
    input  logic        sprite_ovf_set,
    output logic [7:0]  ppuctrl,
    output logic [7:0]  ppumask,
    output logic [14:0] v_addr,
    output logic [14:0] t_addr,
    output logic [2:0]  fine_x,
    output logic [13:0] vram_addr,
    output logic        vram_rd_en,
    output logic        vram_wr_en,
    output logic [7:0]  vram_wr_data,
    input  logic [7:0]  vram_rd_data,
    output logic [7:0]  oam_addr,
    output logic        oam_wr_en,
    output logic [7:0]  oam_wr_data,
    input  logic [7:0]  oam_rd_data,
    output logic        nmi_n,
    output logic        oamdma_start,
    output logic [7:0]  oamdma_page
);

    logic       acc_wr, acc_rd, status_rd;
    logic       w;
    logic       vblank, s0_hit, ovf;
    logic [7:0] io_latch;
    logic       vram_data_load;
    logic [7:0] vram_data_value;

    assign acc_wr    = clock_en && reg_en && reg_rw;
    assign acc_rd    = clock_en && reg_en && !reg_rw;
    assign status_rd = acc_rd && (reg_sel == REG_PPUSTATUS);

    ppu_vram_access u_vram (
        .clock        (clock),
        .reset_n      (reset_n),
        .rd_req       (acc_rd && reg_sel == REG_PPUDATA),
        .wr_req       (acc_wr && reg_sel == REG_PPUDATA),
        .wr_data      (reg_data_wr),
        .inc32        (ppuctrl[2]),
        .v_load       (acc_wr && reg_sel == REG_PPUADDR && w),
        .v_load_val   ({t_addr[14:8], reg_data_wr}),
        .vram_rd_data (vram_rd_data),
        .v_addr       (v_addr),
        .vram_addr    (vram_addr),
        .vram_rd_en   (vram_rd_en),
        .vram_wr_en   (vram_wr_en),
        .vram_wr_data (vram_wr_data),
        .data_load    (vram_data_load),
        .data_value   (vram_data_value)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            reg_data_rd  <= 8'h00;
            ppuctrl      <= 8'h00;
            ppumask      <= 8'h00;
            t_addr       <= 15'h0000;
            fine_x       <= 3'd0;
            w            <= 1'b0;
            vblank       <= 1'b0;
            s0_hit       <= 1'b0;
            ovf          <= 1'b0;
            io_latch     <= 8'h00;
            oam_addr     <= 8'h00;
            oam_wr_en    <= 1'b0;
            oam_wr_data  <= 8'h00;
            nmi_n        <= 1'b1;
            oamdma_start <= 1'b0;
            oamdma_page  <= 8'h00;
        end else begin
            oam_wr_en    <= 1'b0;
            oamdma_start <= 1'b0;
            // OAMDATA strobe goes out with the old address; the increment lands behind it.
            if (oam_wr_en) oam_addr <= oam_addr + 8'd1;
            nmi_n <= ~(vblank & ppuctrl[7]);

            // A status read racing vblank_set wins, which is what suppresses the NMI.
            if (vblank_clear || status_rd) vblank <= 1'b0;
            else if (vblank_set)           vblank <= 1'b1;
            if (vblank_clear) begin
                s0_hit <= 1'b0;
                ovf    <= 1'b0;
            end else begin
                if (sprite0_hit_set) s0_hit <= 1'b1;
                if (sprite_ovf_set)  ovf    <= 1'b1;
            end

            if (vram_data_load) reg_data_rd <= vram_data_value;

            if (acc_wr) begin
                io_latch <= reg_data_wr;
                case (reg_sel)
                    REG_PPUCTRL: begin
                        ppuctrl       <= reg_data_wr;
                        t_addr[11:10] <= reg_data_wr[1:0];
                    end
                    REG_PPUMASK: ppumask  <= reg_data_wr;
                    REG_OAMADDR: oam_addr <= reg_data_wr;
                    REG_OAMDATA: begin
                        oam_wr_en   <= 1'b1;
                        oam_wr_data <= reg_data_wr;
                    end
                    REG_PPUSCROLL: begin
                        if (!w) begin
                            t_addr[4:0] <= reg_data_wr[7:3];
                            fine_x      <= reg_data_wr[2:0];
                        end else begin
                            t_addr[14:12] <= reg_data_wr[2:0];
                            t_addr[9:5]   <= reg_data_wr[7:3];
                        end
                        w <= ~w;
                    end
                    REG_PPUADDR: begin
                        if (!w) t_addr[14:8] <= {1'b0, reg_data_wr[5:0]};
                        else    t_addr[7:0]  <= reg_data_wr;
                        w <= ~w;
                    end
                    REG_OAMDMA: begin
                        oamdma_page  <= reg_data_wr;
                        oamdma_start <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (acc_rd) begin
                case (reg_sel)
                    REG_PPUSTATUS: begin
                        reg_data_rd <= {vblank, s0_hit, ovf, io_latch[4:0]};
                        w           <= 1'b0;
                    end
                    REG_OAMDATA: reg_data_rd <= oam_rd_data;
                    REG_PPUDATA: ;
                    default:     reg_data_rd <= io_latch;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppu_reg_file.sv
// Randomized bench for ppu_reg_file against a register-level behavioural model.
module tb_ppu_reg_file;
    import ppu_reg_file_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clock_en = 1'b0, reg_en = 1'b0, reg_rw = 1'b0;
    reg_t        reg_sel = REG_PPUCTRL;
    logic [7:0]  reg_data_wr = 8'h00;
    logic [7:0]  reg_data_rd;
    logic        vblank_set = 1'b0, vblank_clear = 1'b0;
    logic        sprite0_hit_set = 1'b0, sprite_ovf_set = 1'b0;
    logic [7:0]  ppuctrl, ppumask;
    logic [14:0] v_addr, t_addr;
    logic [2:0]  fine_x;
    logic [13:0] vram_addr;
    logic        vram_rd_en, vram_wr_en;
    logic [7:0]  vram_wr_data, vram_rd_data;
    logic [7:0]  oam_addr, oam_wr_data, oam_rd_data;
    logic        oam_wr_en, nmi_n, oamdma_start;
    logic [7:0]  oamdma_page;

    ppu_reg_file dut (
        .clock(clock), .reset_n(reset_n), .clock_en(clock_en), .reg_en(reg_en),
        .reg_rw(reg_rw), .reg_sel(reg_sel), .reg_data_wr(reg_data_wr),
        .reg_data_rd(reg_data_rd), .vblank_set(vblank_set), .vblank_clear(vblank_clear),
        .sprite0_hit_set(sprite0_hit_set), .sprite_ovf_set(sprite_ovf_set),
        .ppuctrl(ppuctrl), .ppumask(ppumask), .v_addr(v_addr), .t_addr(t_addr),
        .fine_x(fine_x), .vram_addr(vram_addr), .vram_rd_en(vram_rd_en),
        .vram_wr_en(vram_wr_en), .vram_wr_data(vram_wr_data), .vram_rd_data(vram_rd_data),
        .oam_addr(oam_addr), .oam_wr_en(oam_wr_en), .oam_wr_data(oam_wr_data),
        .oam_rd_data(oam_rd_data), .nmi_n(nmi_n), .oamdma_start(oamdma_start),
        .oamdma_page(oamdma_page)
    );

    always #5 clock = ~clock;

    // Memories behind the DUT strobes
    logic [7:0] vram [16384] = '{default: 8'h00};
    logic [7:0] oam  [256]   = '{default: 8'h00};
    assign vram_rd_data = vram[vram_addr];
    assign oam_rd_data  = oam[oam_addr];
    always @(posedge clock) begin
        if (vram_wr_en) vram[vram_addr] <= vram_wr_data;
        if (oam_wr_en)  oam[oam_addr]   <= oam_wr_data;
    end

    // Reference model
    logic [7:0] ref_vram [16384] = '{default: 8'h00};
    logic [7:0] ref_oam  [256]   = '{default: 8'h00};
    int m_ctrl, m_mask, m_v, m_t, m_fx, m_w, m_oam, m_latch, m_buf, m_page;
    int m_vbl, m_s0, m_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_nmi();
        return (m_vbl == 1 && (m_ctrl / 128) % 2 == 1) ? 0 : 1;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_mask = 0; m_v = 0; m_t = 0; m_fx = 0; m_w = 0; m_oam = 0;
        m_latch = 0; m_buf = 0; m_page = 0; m_vbl = 0; m_s0 = 0; m_ovf = 0;
    endtask

    task automatic check_reset_vals();
        check("rst_reg_data_rd", reg_data_rd, 0);
        check("rst_ppuctrl", ppuctrl, 0);
        check("rst_ppumask", ppumask, 0);
        check("rst_v_addr", v_addr, 0);
        check("rst_t_addr", t_addr, 0);
        check("rst_fine_x", fine_x, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_vram_rd_en", vram_rd_en, 0);
        check("rst_vram_wr_en", vram_wr_en, 0);
        check("rst_vram_wr_data", vram_wr_data, 0);
        check("rst_oam_addr", oam_addr, 0);
        check("rst_oam_wr_en", oam_wr_en, 0);
        check("rst_oam_wr_data", oam_wr_data, 0);
        check("rst_nmi_n", nmi_n, 1);
        check("rst_oamdma_start", oamdma_start, 0);
        check("rst_oamdma_page", oamdma_page, 0);
    endtask

    // One CPU cycle (3 clocks): access, then two quiet clocks.
    task automatic cpu_op(input logic rw, input reg_t sel, input logic [7:0] d, input logic vs_with);
        int dv, a, exp_rd, step, e_addr, e_oaddr;
        logic pal, e_vwr, e_vrd, e_owr, e_dma;
        dv = int'(d); a = 0; exp_rd = 0; e_addr = 0; e_oaddr = 0;
        pal = 0; e_vwr = 0; e_vrd = 0; e_owr = 0; e_dma = 0;
        step = ((m_ctrl / 4) % 2 == 1) ? 32 : 1;
        if (rw) begin
            m_latch = dv;
            case (sel)
                REG_PPUCTRL:  begin m_ctrl = dv; m_t = (m_t & 'h73FF) | ((dv % 4) * 1024); end
                REG_PPUMASK:  m_mask = dv;
                REG_OAMADDR:  m_oam = dv;
                REG_OAMDATA:  begin e_owr = 1; e_oaddr = m_oam; ref_oam[m_oam] = d; m_oam = (m_oam + 1) % 256; end
                REG_PPUSCROLL: begin
                    if (m_w == 0) begin m_t = (m_t & 'h7FE0) | (dv / 8); m_fx = dv % 8; end
                    else m_t = (m_t & 'h0C1F) | ((dv % 8) * 4096) | ((dv / 8) * 32);
                    m_w = 1 - m_w;
                end
                REG_PPUADDR: begin
                    if (m_w == 0) m_t = (m_t & 'h00FF) | ((dv % 64) * 256);
                    else begin m_t = (m_t & 'h7F00) | dv; m_v = m_t; end
                    m_w = 1 - m_w;
                end
                REG_PPUDATA: begin
                    a = m_v % 16384; e_vwr = 1; e_addr = a; ref_vram[a] = d;
                    m_v = (m_v + step) % 32768;
                end
                REG_OAMDMA: begin e_dma = 1; m_page = dv; end
                default: ;
            endcase
        end else begin
            case (sel)
                REG_PPUSTATUS: begin
                    exp_rd = m_vbl * 128 + m_s0 * 64 + m_ovf * 32 + m_latch % 32;
                    m_vbl = 0; m_w = 0;
                end
                REG_OAMDATA: exp_rd = int'(ref_oam[m_oam]);
                REG_PPUDATA: begin
                    a = m_v % 16384; e_vrd = 1; e_addr = a;
                    pal = (a / 256 == 63);
                    exp_rd = pal ? int'(ref_vram[a]) : m_buf;
                    m_buf = int'(ref_vram[a]);
                    m_v = (m_v + step) % 32768;
                end
                default: exp_rd = m_latch;
            endcase
        end
        if (vs_with && !(rw == 1'b0 && sel == REG_PPUSTATUS)) m_vbl = 1;

        clock_en = 1; reg_en = 1; reg_rw = rw; reg_sel = sel; reg_data_wr = d; vblank_set = vs_with;
        @(negedge clock);
        clock_en = 0; reg_en = 0; vblank_set = 0;
        check("vram_wr_en", vram_wr_en, e_vwr);
        check("vram_rd_en", vram_rd_en, e_vrd);
        if (e_vwr || e_vrd) check("vram_addr", vram_addr, e_addr);
        if (e_vwr) check("vram_wr_data", vram_wr_data, dv);
        check("oam_wr_en", oam_wr_en, e_owr);
        if (e_owr) begin
            check("oam_wr_addr", oam_addr, e_oaddr);
            check("oam_wr_data", oam_wr_data, dv);
        end
        check("oamdma_start", oamdma_start, e_dma);
        if (!rw && !pal) check("reg_data_rd", reg_data_rd, exp_rd);
        @(negedge clock);
        if (!rw) check("reg_data_rd_late", reg_data_rd, exp_rd);
        check("ppuctrl", ppuctrl, m_ctrl);
        check("ppumask", ppumask, m_mask);
        check("v_addr", v_addr, m_v);
        check("t_addr", t_addr, m_t);
        check("fine_x", fine_x, m_fx);
        check("oam_addr", oam_addr, m_oam);
        check("oamdma_page", oamdma_page, m_page);
        check("nmi_n", nmi_n, exp_nmi());
        check("strobes_idle", {vram_rd_en, vram_wr_en, oam_wr_en, oamdma_start}, 0);
        @(negedge clock);
    endtask

    task automatic flag_pulse(input logic vs, input logic vc, input logic s0, input logic ov);
        int old_nmi;
        old_nmi = exp_nmi();
        vblank_set = vs; vblank_clear = vc; sprite0_hit_set = s0; sprite_ovf_set = ov;
        @(negedge clock);
        vblank_set = 0; vblank_clear = 0; sprite0_hit_set = 0; sprite_ovf_set = 0;
        check("nmi_lag", nmi_n, old_nmi);
        if (vc) begin m_vbl = 0; m_s0 = 0; m_ovf = 0; end
        else begin
            if (vs) m_vbl = 1;
            if (s0) m_s0 = 1;
            if (ov) m_ovf = 1;
        end
        @(negedge clock);
        check("nmi_n_flag", nmi_n, exp_nmi());
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clock);
        check_reset_vals();
        reset_n = 1;
        @(negedge clock);

        // PPUADDR then PPUDATA write
        cpu_op(1, REG_PPUADDR, 8'h21, 0);
        cpu_op(1, REG_PPUADDR, 8'h08, 0);
        cpu_op(1, REG_PPUDATA, 8'hAB, 0);
        check("plan_v_2109", v_addr, 15'h2109);
        check("plan_mem_2108", vram[14'h2108], 8'hAB);

        // Non-palette buffered reads
        cpu_op(1, REG_PPUADDR, 8'h20, 0);
        cpu_op(1, REG_PPUADDR, 8'h00, 0);
        cpu_op(1, REG_PPUDATA, 8'h11, 0);
        cpu_op(1, REG_PPUDATA, 8'h22, 0);
        cpu_op(1, REG_PPUADDR, 8'h20, 0);
        cpu_op(1, REG_PPUADDR, 8'h00, 0);
        cpu_op(0, REG_PPUDATA, 8'h00, 0);
        check("plan_rd_stale", reg_data_rd, 8'h00);
        cpu_op(0, REG_PPUDATA, 8'h00, 0);
        check("plan_rd_11", reg_data_rd, 8'h11);
        cpu_op(0, REG_PPUDATA, 8'h00, 0);
        check("plan_rdbuf_22", reg_data_rd, 8'h22);

        // Palette read answers directly
        cpu_op(1, REG_PPUADDR, 8'h3F, 0);
        cpu_op(1, REG_PPUADDR, 8'h05, 0);
        cpu_op(1, REG_PPUDATA, 8'h2C, 0);
        cpu_op(1, REG_PPUADDR, 8'h3F, 0);
        cpu_op(1, REG_PPUADDR, 8'h05, 0);
        cpu_op(0, REG_PPUDATA, 8'h00, 0);
        check("plan_pal_rd", reg_data_rd, 8'h2C);

        // Scroll and w reset by status read
        cpu_op(1, REG_PPUSCROLL, 8'h7D, 0);
        cpu_op(1, REG_PPUSCROLL, 8'h5E, 0);
        check("plan_t_coarse_x", t_addr[4:0], 5'd15);
        check("plan_fine_x", fine_x, 3'd5);
        check("plan_t_fine_y", t_addr[14:12], 3'd6);
        check("plan_t_coarse_y", t_addr[9:5], 5'd11);
        cpu_op(0, REG_PPUSTATUS, 8'h00, 0);
        cpu_op(1, REG_PPUSCROLL, 8'h08, 0);
        check("plan_w_cleared", t_addr[4:0], 5'd1);
        cpu_op(1, REG_PPUSCROLL, 8'h00, 0);

        // NMI and suppression
        cpu_op(1, REG_PPUCTRL, 8'h80, 0);
        flag_pulse(1, 0, 0, 0);
        check("plan_nmi_low", nmi_n, 0);
        cpu_op(0, REG_PPUSTATUS, 8'h00, 0);
        check("plan_status_vbl", reg_data_rd[7], 1);
        check("plan_nmi_rise", nmi_n, 1);
        cpu_op(0, REG_PPUSTATUS, 8'h00, 1);
        check("plan_suppress_vbl", reg_data_rd[7], 0);
        repeat (3) @(negedge clock);
        check("plan_suppress_nmi", nmi_n, 1);
        flag_pulse(1, 1, 0, 0);

        // OAM wrap and DMA
        cpu_op(1, REG_OAMADDR, 8'hFF, 0);
        cpu_op(1, REG_OAMDATA, 8'h33, 0);
        check("plan_oam_wrap", oam_addr, 8'h00);
        check("plan_oam_mem", oam[8'hFF], 8'h33);
        cpu_op(1, REG_OAMDMA, 8'h02, 0);
        check("plan_dma_page", oamdma_page, 8'h02);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                logic vc;
                vc = ($urandom_range(0, 3) == 0);
                flag_pulse(1'($urandom), vc, vc ? 1'b0 : 1'($urandom), vc ? 1'b0 : 1'($urandom));
            end else begin
                cpu_op(1'($urandom), reg_t'($urandom_range(0, 8)), 8'($urandom),
                       ($urandom_range(0, 7) == 0));
            end
        end

        // Reset during RD_CAP
        cpu_op(1, REG_PPUCTRL, 8'h00, 0);
        cpu_op(1, REG_PPUADDR, 8'h23, 0);
        cpu_op(1, REG_PPUADDR, 8'h40, 0);
        clock_en = 1; reg_en = 1; reg_rw = 0; reg_sel = REG_PPUDATA;
        @(negedge clock);
        clock_en = 0; reg_en = 0;
        check("mid_rd_en", vram_rd_en, 1);
        reset_n = 0;
        @(negedge clock);
        check_reset_vals();
        @(negedge clock);
        check("post_rst_rd_en", vram_rd_en, 0);
        reset_n = 1;
        model_reset();
        @(negedge clock);
        cpu_op(0, REG_PPUDATA, 8'h00, 0);
        check("post_rst_rdbuf", reg_data_rd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ppu_reg_file.md
# ppu_reg_file

CPU-facing PPU register responder: the target end of the CPU's memory-mapped PPU register interface ($2000–$3FFF mirrored by 8, plus $4014). It decodes single-cycle register accesses and applies all side effects. It holds PPUCTRL, PPUMASK, the status flags, OAMADDR, the scroll/address registers (v, t, fine_x, w) and the PPUDATA read buffer. It drives the VRAM, OAM and NMI signals consumed by the PPU rendering pipeline and the OAM DMA engine.

## Interface
Parameters: none.

Ports:
- clock  in  1  PPU clock; the block steps on every edge.
- reset_n  in  1  Reset, **synchronous, active-low**.
- clock_en  in  1  CPU cycle strobe. Asserted at most once every 3 clocks.
- reg_en  in  1  Register access request. Qualified by clock_en.
- reg_rw  in  1  Access direction: 1 = write, 0 = read.
- reg_sel  in  reg_t  Register select: PPUCTRL … PPUDATA, OAMDMA.
- reg_data_wr  in  8  CPU write data.
- reg_data_rd  out  8  CPU read data (registered).
- vblank_set, vblank_clear  in  1  Single-clock pulses from the PPU timing logic.
- sprite0_hit_set, sprite_ovf_set  in  1  Single-clock pulses from the PPU timing logic.
- ppuctrl, ppumask  out  8  Register contents.
- v_addr  out  15  Current VRAM address, v.
- t_addr  out  15  Temporary VRAM address, t.
- fine_x  out  3  Fine X scroll.
- vram_addr  out  14  VRAM access address.
- vram_rd_en, vram_wr_en  out  1  VRAM strobes.
- vram_wr_data  out  8  VRAM write data.
- vram_rd_data  in  8  VRAM read data, valid 1 clock after vram_rd_en.
- oam_addr  out  8  OAM address.
- oam_wr_en  out  1  OAM write strobe.
- oam_wr_data  out  8  OAM write data.
- oam_rd_data  in  8  OAM read data (combinational).
- nmi_n  out  1  Active-low NMI.
- oamdma_start  out  1  One-clock pulse when OAMDMA is written.
- oamdma_page  out  8  DMA source page.

## Operation
- **Access definition:** an access occurs on an edge where clock_en && reg_en. All side effects commit on that edge.
- **io_latch:** every write loads io_latch <= reg_data_wr. Reads of write-only registers return io_latch.
- **PPUCTRL write:** ppuctrl <= d; t[11:10] <= d[1:0].
- **PPUMASK write:** ppumask <= d.
- **PPUSTATUS read:**
  - reg_data_rd <= {vblank, s0_hit, ovf, io_latch[4:0]}.
  - Then vblank <= 0 and w <= 0.
- **OAMADDR write:** oam_addr <= d.
- **OAMDATA write:** oam_wr_en pulses with the current oam_addr; oam_addr then increments, wrapping 8'hFF→8'h00.
- **OAMDATA read:** reg_data_rd <= oam_rd_data. No increment.
- **PPUSCROLL write:**
  - w=0: t[4:0] <= d[7:3]; fine_x <= d[2:0].
  - w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3].
  - w toggles on every write.
- **PPUADDR write:**
  - w=0: t[13:8] <= d[5:0]; t[14] <= 0.
  - w=1: t[7:0] <= d; v <= t with the new low byte.
  - w toggles on every write.
- **PPUDATA access:** handled by the VRAM FSM (below). After the access, v <= v + (ppuctrl[2] ? 32 : 1), modulo 2^15.
- **OAMDMA write:** oamdma_page <= d; oamdma_start pulses for 1 clock.
- **VRAM FSM states:** IDLE, RD_CAP, WR_STB.
  - **PPUDATA read from IDLE:**
    - If v[13:8] != 6'h3F: reg_data_rd <= rd_buf.
    - In all cases: vram_addr <= v[13:0], vram_rd_en <= 1, go to RD_CAP.
  - **RD_CAP:**
    - rd_buf <= vram_rd_data.
    - If the access was a palette access (v[13:8] == 6'h3F), reg_data_rd <= vram_rd_data as well.
    - Return to IDLE.
  - **PPUDATA write from IDLE:** vram_addr <= v[13:0], vram_wr_data <= d, vram_wr_en <= 1, go to WR_STB.
  - **WR_STB:** deassert the strobe and return to IDLE.
- **Flags:**
  - vblank_set sets vblank.
  - sprite0_hit_set and sprite_ovf_set set their flags.
  - vblank_clear clears vblank, s0_hit and ovf.
- **NMI:** nmi_n = ~(vblank & ppuctrl[7]). It is registered, so it lags the flag by 1 clock.

## Timing
- **Reset values:**
  - All outputs, registers, rd_buf, io_latch, w, oamdma_page = 0.
  - nmi_n = 1.
  - All strobes = 0.
  - FSM = IDLE.
- **Reset mid-operation:** any pending VRAM operation is dropped and no strobe is issued afterwards.
- **Read latency:** reg_data_rd is valid the clock after the access edge. For palette PPUDATA reads it is valid 2 clocks after the access edge, which is still inside the same CPU cycle.
- **Strobe width:** vram_rd_en, vram_wr_en, oam_wr_en and oamdma_start are 1 clock wide. Each asserts on the clock after the access edge.
- **Simultaneous vblank_set and PPUSTATUS read:** the read returns vblank=0 and the flag stays clear (NMI suppression).
- **vblank_set and vblank_clear in the same clock:** vblank_clear wins.
- **Non-access edges:** any edge with reg_en=0 or clock_en=0 leaves all state unchanged except the FSM and flag inputs.

## Structure
- reg_t (PPUCTRL…OAMDMA) and the FSM state typedef live in the shared package.
- Sub-module ppu_vram_access owns the VRAM FSM, rd_buf and the v increment.

## Test plan
- **PPUADDR then PPUDATA write:** write $21, $08 to PPUADDR, then $AB to PPUDATA with ppuctrl[2]=0 → vram_wr_en pulse with addr 14'h2108 and data 8'hAB; then v=15'h2109.
- **PPUDATA reads, non-palette:** VRAM[$2000]=$11, [$2001]=$22; set v=$2000; read PPUDATA twice → first read returns stale rd_buf (0), second returns $11; rd_buf then holds $22.
- **PPUSCROLL and w reset:** write $7D then $5E to PPUSCROLL → t[4:0]=15, fine_x=5, t[14:12]=6, t[9:5]=11. Then read PPUSTATUS → w=0.
- **NMI suppression:** ppuctrl=$80. Pulse vblank_set → nmi_n goes low after 1 clock; a PPUSTATUS read returns bit7=1 and nmi_n then rises. Repeat with the PPUSTATUS read coinciding with vblank_set → bit7=0 and nmi_n stays 1.
- **OAM and DMA:** OAMADDR=$FF, write $33 to OAMDATA → oam_wr_en at addr $FF, then oam_addr=$00. Write $02 to OAMDMA → oamdma_start pulse and oamdma_page=$02.
- **Reset mid-operation:** assert reset_n=0 during RD_CAP → no rd_buf update, and all outputs take their reset values at the next edge.
